vfpu_issue_arb: RTL and testbench
=================================

# vfpu_issue_arb

Round-robin issue arbiter that shares one VFPU datapath among N_REQ requesters. It accepts instruction+operand requests over valid/ready handshakes, issues one operation per cycle to the VFPU, and records the requester ID of every in-flight operation in an ordered tag FIFO. It routes each VFPU result back to the originating requester. It sits between the requester-side agents/drivers and the VFPU wrapper's `op_vld`/`res_rdy` interface.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DEPTH, 8, max outstanding VFPU operations; power of 2, ≥2
- INS_W, 6, instruction encoding width
- DW, 32, single-precision data width
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- req_vld  input  N_REQ  per-requester request valid
- req_rdy  output  N_REQ  per-requester grant; at most one bit set
- req_ins  input  N_REQ*INS_W  instruction, requester i at [i*INS_W +: INS_W]
- req_a / req_b / req_c  input  N_REQ*DW each  operands, requester i at [i*DW +: DW]
- vfpu_ins  output  INS_W  issued instruction
- operand_a / operand_b / operand_c  output  DW each  issued operands
- op_vld  output  1  one-cycle issue strobe to VFPU
- res  input  DW  VFPU result
- res_rdy  input  1  VFPU result strobe; results return in issue order
- rsp_vld  output  N_REQ  one-hot result-valid to owning requester
- rsp_res  output  DW  result data, shared by all requesters
- outstanding  output  $clog2(DEPTH+1)  in-flight count
- err_orphan  output  1  sticky: res_rdy seen with empty tag FIFO

## Operation
- A handshake fires for requester i when `req_vld[i] & req_rdy[i]`.
- Arbitration is combinational round-robin. Priority order starts at `ptr` and wraps modulo N_REQ. The lowest-index valid in that order wins.
- `ptr` loads winner+1 (mod N_REQ) on each handshake. It is unchanged when no handshake fires. Reset value is 0, so requester 0 has highest priority.
- `req_rdy` is all-zero when `outstanding == DEPTH`. This holds even if `res_rdy` pops a tag in the same cycle; there is no same-cycle bypass.
- On a handshake:
  - Winner's ins/a/b/c are registered onto the VFPU outputs.
  - `op_vld` is registered high.
  - Winner index is pushed into the tag FIFO.
- Without a handshake, `op_vld` is 0 and the operand/ins registers hold their previous values.
- On `res_rdy` with a non-empty FIFO:
  - Head tag is popped.
  - `rsp_res` is registered from `res`.
  - `rsp_vld` is registered as the one-hot of the tag.
- On `res_rdy` with an empty FIFO: no pop, `rsp_vld` stays 0, and `err_orphan` is set. `err_orphan` is cleared only by reset.
- Push and pop in the same cycle are allowed. In that case `outstanding` is unchanged.
- Tag FIFO: DEPTH entries of $clog2(N_REQ) bits, with wr/rd pointers wrapping at DEPTH. `outstanding` is the occupancy counter. It never exceeds DEPTH and never underflows.
- Requests are not required to stay asserted. A requester may drop `req_vld` without a grant, and no request is latched.
- Reset clears `ptr`, the FIFO pointers and `outstanding`. The VFPU shares `rst_n`, so no pre-reset result arrives after reset.

## Timing
- Reset values:
  - `op_vld`=0, `vfpu_ins`=0, `operand_a/b/c`=0
  - `rsp_vld`=0, `rsp_res`=0
  - `outstanding`=0, `err_orphan`=0
  - `req_rdy`=0 during reset (reset dominates)
- Issue latency: a handshake in cycle T gives `op_vld`=1 with matching ins/operands in T+1, for exactly one cycle per handshake.
- Sustained throughput is 1 issue/cycle while not full. Back-to-back handshakes produce `op_vld` high on consecutive cycles.
- Response latency: `res_rdy` in cycle R gives `rsp_vld`/`rsp_res` in R+1, for one cycle.
- `outstanding` increments the cycle after a push and decrements the cycle after a pop.
- `err_orphan` rises in R+1 for an orphan `res_rdy` in cycle R.
- Reset asserted mid-stream: in the first cycle after `rst_n` is sampled low, all outputs are at their reset values and any pending handshake is discarded.

## Test plan
- Single request: requester 2 sends ins=6'h05, a=32'h3F800000, b=32'h40000000 at T. Expect `req_rdy`=4'b0100 at T, `op_vld`=1 with those values at T+1, and `outstanding`=1 at T+1. VFPU returns `res`=32'h40400000 at R. Expect `rsp_vld`=4'b0100 and `rsp_res`=32'h40400000 at R+1.
- Fairness: all four `req_vld` held high from reset for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and 8 consecutive `op_vld` pulses.
- Full: DEPTH=8 with no `res_rdy`, requester 1 always valid. Expect 8 grants, then `req_rdy`=0 with `outstanding`=8. A single `res_rdy` gives `rsp_vld`=4'b0010 next cycle and `req_rdy` re-asserts in the cycle after the pop.
- Simultaneous push/pop at `outstanding`=3. Expect `outstanding` to stay 3, and response tags to return in issue order for mixed requesters 3,0,2.
- Orphan: `res_rdy` pulse with the FIFO empty. Expect `rsp_vld`=0 and `err_orphan`=1 the next cycle, held until `rst_n`=0.
- Reset mid-op: 5 ops outstanding, then `rst_n` low for 1 cycle. Expect `outstanding`=0, `op_vld`=0, `ptr` back to 0, and requester 0 winning the next all-valid cycle.

Source files
------------

// File: rtl/vfpu_issue_arb_if.sv
// Bundle between the requester agents, the issue arbiter and the VFPU wrapper.
// The slave modport is the arbiter's view. The master modport is the view of the agents plus the VFPU.
interface vfpu_issue_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned INS_W = 6,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_rdy;
    logic [N_REQ*INS_W-1:0] req_ins;
    logic [N_REQ*DW-1:0]    req_a;
    logic [N_REQ*DW-1:0]    req_b;
    logic [N_REQ*DW-1:0]    req_c;

    logic [INS_W-1:0]       vfpu_ins;
    logic [DW-1:0]          operand_a;
    logic [DW-1:0]          operand_b;
    logic [DW-1:0]          operand_c;
    logic                   op_vld;
    logic [DW-1:0]          res;
    logic                   res_rdy;

    logic [N_REQ-1:0]       rsp_vld;
    logic [DW-1:0]          rsp_res;
    logic [CntW-1:0]        outstanding;
    logic                   err_orphan;

    modport master (
        output req_vld, req_ins, req_a, req_b, req_c, res, res_rdy,
        input  req_rdy, vfpu_ins, operand_a, operand_b, operand_c, op_vld,
        input  rsp_vld, rsp_res, outstanding, err_orphan
    );

    modport slave (
        input  req_vld, req_ins, req_a, req_b, req_c, res, res_rdy,
        output req_rdy, vfpu_ins, operand_a, operand_b, operand_c, op_vld,
        output rsp_vld, rsp_res, outstanding, err_orphan
    );
endinterface

// File: rtl/vfpu_issue_arb.sv
// Round-robin issue arbiter for a shared VFPU. An ordered tag FIFO holds the requester ID of every
// in-flight operation, so that each in-order result can be routed back to the requester that issued it.
module vfpu_issue_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned INS_W = 6,
    parameter int unsigned DW    = 32
) (
    input logic              clk,
    input logic              rst_n,
    vfpu_issue_arb_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Arbitration state
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW:0]    cand;
    logic [IdxW-1:0]  win_idx;
    logic             win_found;
    logic [N_REQ-1:0] grant;
    logic             fire;

    // Tag FIFO
    logic [IdxW-1:0]  tag_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             full, empty, push, pop;

    // Registered outputs
    logic [INS_W-1:0] ins_q;
    logic [DW-1:0]    a_q, b_q, c_q;
    logic             op_vld_q;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [DW-1:0]    rsp_res_q;
    logic             err_q;

    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);

    // Walk the priority order from ptr_q, wrapping modulo N_REQ; the first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(N_REQ)) begin
                cand = cand - (IdxW + 1)'(N_REQ);
            end
            if (!win_found && bus.req_vld[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end

    // Reset and a full FIFO both suppress the grant; a pop in the same cycle does not bypass this.
    always_comb begin
        grant = '0;
        if (rst_n && !full && win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign fire        = |grant;
    assign push        = fire;
    assign pop         = bus.res_rdy && !empty;
    assign bus.req_rdy = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rsp_vld_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_vld_d[i] = pop && (tag_mem[rd_ptr_q] == IdxW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            op_vld_q  <= 1'b0;
            ins_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            op_vld_q  <= fire;
            rsp_vld_q <= rsp_vld_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                ins_q    <= bus.req_ins[win_idx*INS_W +: INS_W];
                a_q      <= bus.req_a[win_idx*DW +: DW];
                b_q      <= bus.req_b[win_idx*DW +: DW];
                c_q      <= bus.req_c[win_idx*DW +: DW];
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rsp_res_q <= bus.res;
            end
            if (bus.res_rdy && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= win_idx;
        end
    end

    assign bus.vfpu_ins    = ins_q;
    assign bus.operand_a   = a_q;
    assign bus.operand_b   = b_q;
    assign bus.operand_c   = c_q;
    assign bus.op_vld      = op_vld_q;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_res     = rsp_res_q;
    assign bus.outstanding = cnt_q;
    assign bus.err_orphan  = err_q;
endmodule

// File: tb/tb_vfpu_issue_arb.sv
// Directed bench for vfpu_issue_arb: covers reset, single issue, fairness, full gating,
// push/pop ordering, orphan results and reset mid-stream.
module tb_vfpu_issue_arb;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned INS_W = 6;
    localparam int unsigned DW    = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vfpu_issue_arb_if #(.N_REQ(N_REQ), .DEPTH(DEPTH), .INS_W(INS_W), .DW(DW)) bus ();

    vfpu_issue_arb #(.N_REQ(N_REQ), .DEPTH(DEPTH), .INS_W(INS_W), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.req_vld = '0;
        bus.req_ins = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.req_c   = '0;
        bus.res     = '0;
        bus.res_rdy = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [INS_W-1:0] ins, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] c);
        bus.req_ins[i*INS_W +: INS_W] = ins;
        bus.req_a[i*DW +: DW]         = a;
        bus.req_b[i*DW +: DW]         = b;
        bus.req_c[i*DW +: DW]         = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_payloads();
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 6'(i + 1), 32'h100 + i, 32'h200 + i, 32'h300 + i);
        end
    endtask

    initial begin
        int tags[3];
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear_in();

        // Reset values, with every requester valid
        load_payloads();
        bus.req_vld = 4'hF;
        tick();
        tick();
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_op_vld", bus.op_vld, 0);
        check("rst_vfpu_ins", bus.vfpu_ins, 0);
        check("rst_operand_a", bus.operand_a, 0);
        check("rst_operand_c", bus.operand_c, 0);
        check("rst_rsp_vld", bus.rsp_vld, 0);
        check("rst_rsp_res", bus.rsp_res, 0);
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_err_orphan", bus.err_orphan, 0);

        // Single request from requester 2
        clear_in();
        rst_n = 1'b1;
        set_req(2, 6'h05, 32'h3F800000, 32'h40000000, 32'h0);
        bus.req_vld = 4'b0100;
        #1 check("single_rdy", bus.req_rdy, 4'b0100);
        tick();
        bus.req_vld = '0;
        check("single_op_vld", bus.op_vld, 1);
        check("single_ins", bus.vfpu_ins, 6'h05);
        check("single_a", bus.operand_a, 32'h3F800000);
        check("single_b", bus.operand_b, 32'h40000000);
        check("single_outstanding", bus.outstanding, 1);
        tick();
        check("single_op_vld_drop", bus.op_vld, 0);
        check("single_ins_hold", bus.vfpu_ins, 6'h05);
        bus.res     = 32'h40400000;
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        check("single_rsp_vld", bus.rsp_vld, 4'b0100);
        check("single_rsp_res", bus.rsp_res, 32'h40400000);
        check("single_out_zero", bus.outstanding, 0);
        tick();
        check("single_rsp_drop", bus.rsp_vld, 0);

        // Fairness: all valid from reset, grant order 0,1,2,3,0,1,2,3
        clear_in();
        load_payloads();
        bus.req_vld = 4'hF;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            #1 check("fair_grant", bus.req_rdy, 64'(1) << (k % 4));
            tick();
            check("fair_op_vld", bus.op_vld, 1);
            check("fair_ins", bus.vfpu_ins, 64'((k % 4) + 1));
            check("fair_c", bus.operand_c, 64'(32'h300 + (k % 4)));
        end
        #1 check("fair_full_gate", bus.req_rdy, 0);
        check("fair_outstanding", bus.outstanding, 8);

        // Full: requester 1 alone fills the FIFO, then a single pop reopens it
        clear_in();
        do_reset();
        set_req(1, 6'h11, 32'h1, 32'h2, 32'h3);
        bus.req_vld = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            #1 check("full_grant", bus.req_rdy, 4'b0010);
            tick();
        end
        check("full_outstanding", bus.outstanding, 8);
        check("full_rdy_low", bus.req_rdy, 0);
        tick();
        check("full_no_issue", bus.op_vld, 0);
        bus.res     = 32'hAA;
        bus.res_rdy = 1'b1;
        #1 check("full_no_bypass", bus.req_rdy, 0);
        tick();
        bus.res_rdy = 1'b0;
        check("full_rsp_vld", bus.rsp_vld, 4'b0010);
        check("full_out_7", bus.outstanding, 7);
        #1 check("full_rdy_back", bus.req_rdy, 4'b0010);

        // Simultaneous push/pop at outstanding 3, issue order 3,0,2
        clear_in();
        do_reset();
        load_payloads();
        tags = '{3, 0, 2};
        for (int k = 0; k < 3; k++) begin
            bus.req_vld = 4'(1 << tags[k]);
            tick();
        end
        bus.req_vld = '0;
        check("pp_out_3", bus.outstanding, 3);
        bus.req_vld = 4'b0001;
        bus.res     = 32'hA0;
        bus.res_rdy = 1'b1;
        tick();
        bus.req_vld = '0;
        check("pp_out_hold", bus.outstanding, 3);
        check("pp_rsp_vld0", bus.rsp_vld, 4'b1000);
        check("pp_rsp_res0", bus.rsp_res, 32'hA0);
        check("pp_issue", bus.op_vld, 1);
        // Remaining tags in order: 0, 2, then the 0 pushed during the pop
        tags = '{0, 2, 0};
        for (int k = 0; k < 3; k++) begin
            bus.res     = 32'hB0 + k;
            bus.res_rdy = 1'b1;
            tick();
            check("pp_rsp_vld", bus.rsp_vld, 64'(1) << tags[k]);
            check("pp_rsp_res", bus.rsp_res, 64'(32'hB0 + k));
        end
        bus.res_rdy = 1'b0;
        check("pp_out_empty", bus.outstanding, 0);

        // Orphan result with an empty FIFO
        bus.res     = 32'hDEAD;
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        check("orph_rsp_vld", bus.rsp_vld, 0);
        check("orph_err", bus.err_orphan, 1);
        check("orph_out", bus.outstanding, 0);
        tick();
        tick();
        tick();
        check("orph_sticky", bus.err_orphan, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("orph_cleared", bus.err_orphan, 0);

        // Reset mid-stream with 5 operations outstanding
        clear_in();
        do_reset();
        load_payloads();
        bus.req_vld = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        check("mid_out_5", bus.outstanding, 5);
        rst_n = 1'b0;
        #1 check("mid_rdy_rst", bus.req_rdy, 0);
        tick();
        check("mid_out_0", bus.outstanding, 0);
        check("mid_op_vld", bus.op_vld, 0);
        check("mid_ins", bus.vfpu_ins, 0);
        rst_n = 1'b1;
        #1 check("mid_ptr0", bus.req_rdy, 4'b0001);
        tick();
        check("mid_issue", bus.op_vld, 1);
        check("mid_issue_ins", bus.vfpu_ins, 6'h01);
        check("mid_out_1", bus.outstanding, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
